// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall hold buffer and redirect handling.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_shouldStall,
    input  logic        ex_shouldJumpOrBranch,
    input  logic [31:0] ex_jumpTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_4,
    output logic [31:0] if_instruction,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_buf, hold_buf_next;
    logic [31:0] pend_target, pend_target_next;
    logic [31:0] pc_plus_4;
    logic [31:0] target_aligned;

    assign pc_plus_4      = pc + 32'd4;
    assign target_aligned = {ex_jumpTarget[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= {RESET_PC[31:2], 2'b00};
            hold_buf    <= '0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            hold_buf    <= hold_buf_next;
            pend_target <= pend_target_next;
        end
    end

    // Redirect is tested before stall in every state so it always wins.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        hold_buf_next    = hold_buf;
        pend_target_next = pend_target;
        imem_req         = 1'b0;
        imem_addr        = pc;
        if_instruction   = '0;
        if_pc_4          = pc_plus_4;

        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (ex_shouldJumpOrBranch) begin
                    if (imem_ready) begin
                        pc_next = target_aligned;
                    end else begin
                        pend_target_next = ex_jumpTarget;
                        state_next       = DISCARD;
                    end
                end else if (imem_ready) begin
                    if_instruction = imem_rdata;
                    if (id_shouldStall) begin
                        hold_buf_next = imem_rdata;
                        state_next    = HOLD;
                    end else begin
                        pc_next = pc_plus_4;
                    end
                end
            end
            HOLD: begin
                if (ex_shouldJumpOrBranch) begin
                    pc_next    = target_aligned;
                    state_next = FETCH;
                end else begin
                    if_instruction = hold_buf;
                    if (!id_shouldStall) begin
                        pc_next    = pc_plus_4;
                        state_next = FETCH;
                    end
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (ex_shouldJumpOrBranch) begin
                    pend_target_next = ex_jumpTarget;
                end
                if (imem_ready) begin
                    pc_next    = ex_shouldJumpOrBranch ? target_aligned
                                                       : {pend_target[31:2], 2'b00};
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Reset overrides the visible outputs; any imem_ready this cycle is ignored.
        if (rst) begin
            imem_req       = 1'b0;
            if_instruction = '0;
            if_pc_4        = RESET_PC + 32'd4;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetched_q, bubbles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (if_instruction != '0 && !id_shouldStall && !ex_shouldJumpOrBranch)
                fetched_q <= fetched_q + 32'd1;
            if (if_instruction == '0)
                bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_shouldStall;
    logic        ex_shouldJumpOrBranch;
    logic [31:0] ex_jumpTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    typedef struct {
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_id   = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .id_shouldStall        (id_shouldStall),
        .ex_shouldJumpOrBranch (ex_shouldJumpOrBranch),
        .ex_jumpTarget         (ex_jumpTarget),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_ready            (imem_ready),
        .imem_rdata            (imem_rdata),
        .if_pc_4               (if_pc_4),
        .if_instruction        (if_instruction),
        .perf_fetched          (perf_fetched),
        .perf_bubbles          (perf_bubbles)
    );

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_req", e.cyc, {31'b0, imem_req}, {31'b0, e.req});
            if (e.chk_addr) chk("imem_addr", e.cyc, imem_addr, e.addr);
            chk("if_instruction", e.cyc, if_instruction, e.instr);
            chk("if_pc_4", e.cyc, if_pc_4, e.pc4);
`ifndef IF_PERF_COUNTERS_EN
            chk("perf_fetched", e.cyc, perf_fetched, 32'h0);
            chk("perf_bubbles", e.cyc, perf_bubbles, 32'h0);
`endif
        end
    end

    // One cycle of stimulus: drive inputs just after the edge, queue expected outputs.
    task automatic step(input logic r, input logic stall, input logic redir,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata,
                        input logic e_req, input logic e_chk_addr, input logic [31:0] e_addr,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4);
        exp_t e;
        @(posedge clk);
        #1;
        rst                   = r;
        id_shouldStall        = stall;
        ex_shouldJumpOrBranch = redir;
        ex_jumpTarget         = tgt;
        imem_ready            = rdy;
        imem_rdata            = rdata;
        e.req      = e_req;
        e.chk_addr = e_chk_addr;
        e.addr     = e_addr;
        e.instr    = e_instr;
        e.pc4      = e_pc4;
        e.cyc      = cyc_id;
        cyc_id++;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; id_shouldStall = 1'b0; ex_shouldJumpOrBranch = 1'b0;
        ex_jumpTarget = '0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;

        //   rst stl rdr target        rdy rdata          req ca addr           instr          pc4
        step(1, 0, 0, 32'h0,         1, 32'h1234_5678, 0, 0, 32'h0,         32'h0,         32'h104);
        step(1, 1, 1, 32'h55,        1, 32'h1234_5678, 0, 0, 32'h0,         32'h0,         32'h104);
        // sequential fetch from RESET_PC
        step(0, 0, 0, 32'h0,         1, 32'hA100,      1, 1, 32'h100,       32'hA100,      32'h104);
        // stall on 0x104 for three cycles, released on the fourth
        step(0, 1, 0, 32'h0,         1, 32'hA104,      1, 1, 32'h104,       32'hA104,      32'h108);
        step(0, 1, 0, 32'h0,         1, 32'hBAD0,      0, 0, 32'h0,         32'hA104,      32'h108);
        step(0, 1, 0, 32'h0,         1, 32'hBAD1,      0, 0, 32'h0,         32'hA104,      32'h108);
        step(0, 0, 0, 32'h0,         1, 32'hBAD2,      0, 0, 32'h0,         32'hA104,      32'h108);
        step(0, 0, 0, 32'h0,         1, 32'hA108,      1, 1, 32'h108,       32'hA108,      32'h10C);
        // redirect to unaligned 0x203 with ready=1
        step(0, 0, 1, 32'h203,       1, 32'hA10C,      1, 1, 32'h10C,       32'h0,         32'h110);
        step(0, 0, 0, 32'h0,         0, 32'hCCCC,      1, 1, 32'h200,       32'h0,         32'h204);
        // redirect to 0x300 while memory stalls; late data is dropped
        step(0, 0, 1, 32'h300,       0, 32'hCCCC,      1, 1, 32'h200,       32'h0,         32'h204);
        step(0, 0, 0, 32'h0,         0, 32'hCCCC,      1, 1, 32'h200,       32'h0,         32'h204);
        step(0, 0, 0, 32'h0,         1, 32'hDEAD,      1, 1, 32'h200,       32'h0,         32'h204);
        // stall into HOLD, then redirect plus stall together
        step(0, 1, 0, 32'h0,         1, 32'hA300,      1, 1, 32'h300,       32'hA300,      32'h304);
        step(0, 1, 1, 32'h400,       1, 32'hBAD3,      0, 0, 32'h0,         32'h0,         32'h304);
        step(0, 0, 0, 32'h0,         1, 32'hA400,      1, 1, 32'h400,       32'hA400,      32'h404);
        // DISCARD: latest redirect wins, same-cycle redirect beats pend_target
        step(0, 0, 1, 32'h500,       0, 32'hCCCC,      1, 1, 32'h404,       32'h0,         32'h408);
        step(0, 0, 1, 32'h600,       0, 32'hCCCC,      1, 1, 32'h404,       32'h0,         32'h408);
        step(0, 0, 1, 32'h700,       1, 32'hDEAD,      1, 1, 32'h404,       32'h0,         32'h408);
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hA700,      1, 1, 32'h700,       32'h0,         32'h704);
        // PC wrap at the top of the address space
        step(0, 0, 0, 32'h0,         1, 32'hAFFC,      1, 1, 32'hFFFF_FFFC, 32'hAFFC,      32'h0);
        step(0, 0, 0, 32'h0,         1, 32'hA000,      1, 1, 32'h0,         32'hA000,      32'h4);
        // reset mid-request ignores ready/data
        step(1, 0, 0, 32'h0,         1, 32'hBEEF,      0, 0, 32'h0,         32'h0,         32'h104);
        step(0, 0, 0, 32'h0,         1, 32'hB100,      1, 1, 32'h100,       32'hB100,      32'h104);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
